// File: rtl/fu_issue_scheduler.sv
// Issue-stage scheduler: binds ready reservation-station entries to free multi-cycle
// functional units using a rotating scan pointer, and tracks each unit's busy time.
module fu_issue_scheduler #(
    parameter int RS_SZ  = 16,
    parameter int NUM_FU = 4,
    parameter int LAT    = 4,
    parameter int IDX_W  = $clog2(RS_SZ),
    parameter int CNT_W  = $clog2(LAT + 1)
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    input  logic [RS_SZ-1:0]        entry_ready_i,
    input  logic [NUM_FU-1:0]       fu_stall_i,
    input  logic                    squash_i,
    output logic [RS_SZ-1:0]        rs_rd_en_o,
    output logic [NUM_FU-1:0]       issue_valid_o,
    output logic [NUM_FU*IDX_W-1:0] issue_idx_o,
    output logic [NUM_FU-1:0]       fu_busy_o,
    output logic [NUM_FU-1:0]       fu_done_o
);

    logic [CNT_W-1:0]  busy_cnt_q [NUM_FU];
    logic [CNT_W-1:0]  busy_cnt_d [NUM_FU];
    logic [IDX_W-1:0]  issue_idx_q [NUM_FU];
    logic [IDX_W-1:0]  issue_idx_d [NUM_FU];
    logic [NUM_FU-1:0] issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NUM_FU-1:0] fu_free;
    logic [NUM_FU-1:0] avail;
    logic [NUM_FU-1:0] grant_vld;
    logic [IDX_W-1:0]  grant_idx [NUM_FU];
    logic [RS_SZ-1:0]  rd_en;
    logic              any_grant;
    logic              unit_found;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W:0]    pos;
    logic [IDX_W-1:0]  ent;

    always_comb begin
        fu_done_o = '0;
        fu_busy_o = '0;
        fu_free   = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            fu_busy_o[f] = (busy_cnt_q[f] != '0);
            fu_done_o[f] = (busy_cnt_q[f] == CNT_W'(1)) && !fu_stall_i[f] && !squash_i;
            fu_free[f]   = (busy_cnt_q[f] == '0) || fu_done_o[f];
        end
    end

    // Walk entries from rr_ptr with wraparound; each ready entry takes the lowest free unit left.
    // Nothing is granted while reset is held so the RS never frees entries that are not issued.
    always_comb begin
        rd_en      = '0;
        grant_vld  = '0;
        avail      = fu_free;
        any_grant  = 1'b0;
        unit_found = 1'b0;
        last_idx   = '0;
        pos        = '0;
        ent        = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            grant_idx[f] = '0;
        end
        if (!squash_i && reset_ni) begin
            for (int k = 0; k < RS_SZ; k++) begin
                pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
                if (pos >= (IDX_W+1)'(RS_SZ)) begin
                    pos = pos - (IDX_W+1)'(RS_SZ);
                end
                ent = pos[IDX_W-1:0];
                if (entry_ready_i[ent]) begin
                    unit_found = 1'b0;
                    for (int f = 0; f < NUM_FU; f++) begin
                        if (!unit_found && avail[f]) begin
                            unit_found   = 1'b1;
                            avail[f]     = 1'b0;
                            grant_vld[f] = 1'b1;
                            grant_idx[f] = ent;
                            rd_en[ent]   = 1'b1;
                            any_grant    = 1'b1;
                            last_idx     = ent;
                        end
                    end
                end
            end
        end
    end

    assign rs_rd_en_o = rd_en;

    always_comb begin
        issue_valid_d = '0;
        rr_ptr_d      = rr_ptr_q;
        for (int f = 0; f < NUM_FU; f++) begin
            busy_cnt_d[f]  = busy_cnt_q[f];
            issue_idx_d[f] = issue_idx_q[f];
            if (squash_i) begin
                busy_cnt_d[f] = '0;
            end else if (grant_vld[f]) begin
                busy_cnt_d[f]    = CNT_W'(LAT);
                issue_valid_d[f] = 1'b1;
                issue_idx_d[f]   = grant_idx[f];
            end else if (busy_cnt_q[f] > CNT_W'(1)) begin
                busy_cnt_d[f] = busy_cnt_q[f] - CNT_W'(1);
            end else if (busy_cnt_q[f] == CNT_W'(1) && !fu_stall_i[f]) begin
                busy_cnt_d[f] = '0;
            end
        end
        if (any_grant) begin
            rr_ptr_d = (last_idx == IDX_W'(RS_SZ - 1)) ? '0 : last_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int f = 0; f < NUM_FU; f++) begin
                busy_cnt_q[f]  <= '0;
                issue_idx_q[f] <= '0;
            end
            issue_valid_q <= '0;
            rr_ptr_q      <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                busy_cnt_q[f]  <= busy_cnt_d[f];
                issue_idx_q[f] <= issue_idx_d[f];
            end
            issue_valid_q <= issue_valid_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    always_comb begin
        issue_idx_o = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            issue_idx_o[f*IDX_W +: IDX_W] = issue_idx_q[f];
        end
    end

    assign issue_valid_o = issue_valid_q;

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Directed bench for fu_issue_scheduler with default parameters (16 entries, 4 units, LAT=4).
// Registered issue results go through a cycle-stamped scoreboard; combinational outputs are checked inline.
module tb_fu_issue_scheduler;

    logic        clock_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [15:0] entry_ready = '0;
    logic [3:0]  fu_stall = '0;
    logic        squash = 1'b0;
    logic [15:0] rs_rd_en;
    logic [3:0]  issue_valid;
    logic [15:0] issue_idx;
    logic [3:0]  fu_busy;
    logic [3:0]  fu_done;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  vld;
        logic [15:0] idx;
        logic [3:0]  busy;
    } sb_t;

    typedef struct {
        logic [15:0] rdy;
        logic [3:0]  stl;
        logic        sq;
        logic [15:0] rd;
        logic [3:0]  done;
        logic [3:0]  vld;
        logic [15:0] idx;
        logic [3:0]  busy;
    } row_t;

    sb_t sb[$];

    fu_issue_scheduler dut (
        .clock_i      (clock_i),
        .reset_ni     (reset_ni),
        .entry_ready_i(entry_ready),
        .fu_stall_i   (fu_stall),
        .squash_i     (squash),
        .rs_rd_en_o   (rs_rd_en),
        .issue_valid_o(issue_valid),
        .issue_idx_o  (issue_idx),
        .fu_busy_o    (fu_busy),
        .fu_done_o    (fu_done)
    );

    initial forever #5 clock_i = ~clock_i;

    // Scoreboard monitor: compares registered outputs against expectations stamped for this edge.
    initial forever begin
        sb_t e;
        @(posedge clock_i);
        cyc_cnt++;
        #1;
        while (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
            e = sb.pop_front();
            checks++;
            if (issue_valid !== e.vld) begin
                errors++;
                $display("FAIL issue_valid cyc %0d: got %h want %h", cyc_cnt, issue_valid, e.vld);
            end
            checks++;
            if (issue_idx !== e.idx) begin
                errors++;
                $display("FAIL issue_idx cyc %0d: got %h want %h", cyc_cnt, issue_idx, e.idx);
            end
            checks++;
            if (fu_busy !== e.busy) begin
                errors++;
                $display("FAIL fu_busy cyc %0d: got %h want %h", cyc_cnt, fu_busy, e.busy);
            end
        end
    end

    task automatic test_reset();
        entry_ready = '0; fu_stall = '0; squash = 1'b0; reset_ni = 1'b0;
        repeat (3) @(posedge clock_i);
        #1 reset_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock_i);
            checks++;
            if (rs_rd_en !== 16'h0) begin errors++; $display("FAIL reset rd_en c%0d: got %h want 0", c, rs_rd_en); end
            checks++;
            if (issue_valid !== 4'h0) begin errors++; $display("FAIL reset issue_valid c%0d: got %h want 0", c, issue_valid); end
            checks++;
            if (fu_busy !== 4'h0) begin errors++; $display("FAIL reset fu_busy c%0d: got %h want 0", c, fu_busy); end
            checks++;
            if (fu_done !== 4'h0) begin errors++; $display("FAIL reset fu_done c%0d: got %h want 0", c, fu_done); end
            @(posedge clock_i); #1;
        end
    endtask

    // Shared per-test table walk lives inline in each test so every comparison is local to its scenario.
    task automatic test_issue_back_to_back();
        row_t t[$];
        t.push_back(row_t'{16'h00B6, 4'h0, 1'b0, 16'h0036, 4'h0, 4'hF, 16'h5421, 4'hF});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h5421, 4'hF});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h5421, 4'hF});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h5421, 4'hF});
        t.push_back(row_t'{16'h0200, 4'h0, 1'b0, 16'h0200, 4'hF, 4'h1, 16'h5429, 4'h1});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h5429, 4'h1});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h5429, 4'h1});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h5429, 4'h1});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h1, 4'h0, 16'h5429, 4'h0});
        foreach (t[r]) begin
            entry_ready = t[r].rdy; fu_stall = t[r].stl; squash = t[r].sq;
            @(negedge clock_i);
            checks++;
            if (rs_rd_en !== t[r].rd) begin errors++; $display("FAIL issue rd_en row %0d: got %h want %h", r, rs_rd_en, t[r].rd); end
            checks++;
            if (fu_done !== t[r].done) begin errors++; $display("FAIL issue fu_done row %0d: got %h want %h", r, fu_done, t[r].done); end
            sb.push_back(sb_t'{cyc_cnt + 1, t[r].vld, t[r].idx, t[r].busy});
            @(posedge clock_i); #1;
        end
    endtask

    task automatic test_stall();
        row_t t[$];
        t.push_back(row_t'{16'h0C00, 4'h0, 1'b0, 16'h0C00, 4'h0, 4'h3, 16'h54BA, 4'h3});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h54BA, 4'h3});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h54BA, 4'h3});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h54BA, 4'h3});
        t.push_back(row_t'{16'hF000, 4'h2, 1'b0, 16'h7000, 4'h1, 4'hD, 16'hEDBC, 4'hF});
        t.push_back(row_t'{16'h8000, 4'h2, 1'b0, 16'h0000, 4'h0, 4'h0, 16'hEDBC, 4'hF});
        t.push_back(row_t'{16'h8000, 4'h2, 1'b0, 16'h0000, 4'h0, 4'h0, 16'hEDBC, 4'hF});
        t.push_back(row_t'{16'h8000, 4'h0, 1'b0, 16'h8000, 4'h2, 4'h2, 16'hEDFC, 4'hF});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'hD, 4'h0, 16'hEDFC, 4'h2});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'hEDFC, 4'h2});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'hEDFC, 4'h2});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h2, 4'h0, 16'hEDFC, 4'h0});
        foreach (t[r]) begin
            entry_ready = t[r].rdy; fu_stall = t[r].stl; squash = t[r].sq;
            @(negedge clock_i);
            checks++;
            if (rs_rd_en !== t[r].rd) begin errors++; $display("FAIL stall rd_en row %0d: got %h want %h", r, rs_rd_en, t[r].rd); end
            checks++;
            if (fu_done !== t[r].done) begin errors++; $display("FAIL stall fu_done row %0d: got %h want %h", r, fu_done, t[r].done); end
            sb.push_back(sb_t'{cyc_cnt + 1, t[r].vld, t[r].idx, t[r].busy});
            @(posedge clock_i); #1;
        end
    endtask

    task automatic test_wrap();
        row_t t[$];
        t.push_back(row_t'{16'h3000, 4'h0, 1'b0, 16'h3000, 4'h0, 4'h3, 16'hEDDC, 4'h3});
        t.push_back(row_t'{16'h8009, 4'h0, 1'b0, 16'h8001, 4'h0, 4'hC, 16'h0FDC, 4'hF});
        t.push_back(row_t'{16'h0008, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h0FDC, 4'hF});
        t.push_back(row_t'{16'h0008, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h0FDC, 4'hF});
        t.push_back(row_t'{16'h0008, 4'h0, 1'b0, 16'h0008, 4'h3, 4'h1, 16'h0FD3, 4'hD});
        foreach (t[r]) begin
            entry_ready = t[r].rdy; fu_stall = t[r].stl; squash = t[r].sq;
            @(negedge clock_i);
            checks++;
            if (rs_rd_en !== t[r].rd) begin errors++; $display("FAIL wrap rd_en row %0d: got %h want %h", r, rs_rd_en, t[r].rd); end
            checks++;
            if (fu_done !== t[r].done) begin errors++; $display("FAIL wrap fu_done row %0d: got %h want %h", r, fu_done, t[r].done); end
            sb.push_back(sb_t'{cyc_cnt + 1, t[r].vld, t[r].idx, t[r].busy});
            @(posedge clock_i); #1;
        end
    endtask

    // Squash with three busy units (two of them on their final cycle), then confirm rr_ptr held at 4.
    task automatic test_squash();
        row_t t[$];
        t.push_back(row_t'{16'hFFFF, 4'h0, 1'b1, 16'h0000, 4'h0, 4'h0, 16'h0FD3, 4'h0});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h0FD3, 4'h0});
        t.push_back(row_t'{16'h0024, 4'h0, 1'b0, 16'h0024, 4'h0, 4'h3, 16'h0F25, 4'h3});
        foreach (t[r]) begin
            entry_ready = t[r].rdy; fu_stall = t[r].stl; squash = t[r].sq;
            @(negedge clock_i);
            checks++;
            if (rs_rd_en !== t[r].rd) begin errors++; $display("FAIL squash rd_en row %0d: got %h want %h", r, rs_rd_en, t[r].rd); end
            checks++;
            if (fu_done !== t[r].done) begin errors++; $display("FAIL squash fu_done row %0d: got %h want %h", r, fu_done, t[r].done); end
            sb.push_back(sb_t'{cyc_cnt + 1, t[r].vld, t[r].idx, t[r].busy});
            @(posedge clock_i); #1;
        end
        entry_ready = '0; squash = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        row_t t[$];
        @(negedge clock_i);
        reset_ni = 1'b0;
        #1;
        checks++;
        if (fu_busy !== 4'h0) begin errors++; $display("FAIL rstmid fu_busy: got %h want 0", fu_busy); end
        checks++;
        if (issue_valid !== 4'h0) begin errors++; $display("FAIL rstmid issue_valid: got %h want 0", issue_valid); end
        checks++;
        if (issue_idx !== 16'h0) begin errors++; $display("FAIL rstmid issue_idx: got %h want 0", issue_idx); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clock_i);
            checks++;
            if (fu_done !== 4'h0) begin errors++; $display("FAIL rstmid fu_done c%0d: got %h want 0", c, fu_done); end
        end
        @(posedge clock_i); #1;
        reset_ni = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock_i);
            checks++;
            if (fu_done !== 4'h0 || fu_busy !== 4'h0) begin
                errors++; $display("FAIL rstmid after c%0d: done %h busy %h want 0 0", c, fu_done, fu_busy);
            end
            @(posedge clock_i); #1;
        end
        t.push_back(row_t'{16'h0024, 4'h0, 1'b0, 16'h0024, 4'h0, 4'h3, 16'h0052, 4'h3});
        t.push_back(row_t'{16'h0000, 4'h0, 1'b0, 16'h0000, 4'h0, 4'h0, 16'h0052, 4'h3});
        foreach (t[r]) begin
            entry_ready = t[r].rdy; fu_stall = t[r].stl; squash = t[r].sq;
            @(negedge clock_i);
            checks++;
            if (rs_rd_en !== t[r].rd) begin errors++; $display("FAIL rstmid rd_en row %0d: got %h want %h", r, rs_rd_en, t[r].rd); end
            checks++;
            if (fu_done !== t[r].done) begin errors++; $display("FAIL rstmid fu_done row %0d: got %h want %h", r, fu_done, t[r].done); end
            sb.push_back(sb_t'{cyc_cnt + 1, t[r].vld, t[r].idx, t[r].busy});
            @(posedge clock_i); #1;
        end
    endtask

    initial begin
        test_reset();
        test_issue_back_to_back();
        test_stall();
        test_wrap();
        test_squash();
        test_reset_mid_op();
        @(negedge clock_i);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
